// File: rtl/sram_port_arbiter_pkg.sv
// rtl/sram_port_arbiter_pkg.sv - shared widths, FSM state and port encodings
package sram_port_arbiter_pkg;

  localparam int ADDR_W = 18;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WSETUP,
    ST_WPULSE,
    ST_WHOLD,
    ST_DONE
  } state_e;

  typedef enum logic {
    PORT_INST,
    PORT_DATA
  } port_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// rtl/sram_port_arbiter_if.sv - requester ports and SRAM pins of the arbiter
interface sram_port_arbiter_if;
  import sram_port_arbiter_pkg::*;

  logic              inst_read;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_ready;
  logic [DATA_W-1:0] inst_rdata;

  logic              data_read;
  logic              data_write;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic [BE_W-1:0]   data_be;
  logic              data_ready;
  logic [DATA_W-1:0] data_rdata;

  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_dq_o;
  logic              sram_dq_oe;
  logic [DATA_W-1:0] sram_dq_i;
  logic              sram_ce_n;
  logic              sram_oe_n;
  logic              sram_we_n;
  logic [BE_W-1:0]   sram_be_n;

  // Arbiter side
  modport slave (
    input  inst_read, inst_addr, data_read, data_write, data_addr, data_wdata, data_be,
    input  sram_dq_i,
    output inst_ready, inst_rdata, data_ready, data_rdata,
    output sram_addr, sram_dq_o, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_be_n
  );

  // Requester / board side
  modport master (
    output inst_read, inst_addr, data_read, data_write, data_addr, data_wdata, data_be,
    output sram_dq_i,
    input  inst_ready, inst_rdata, data_ready, data_rdata,
    input  sram_addr, sram_dq_o, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_be_n
  );

endinterface

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - two-port arbiter onto a single asynchronous SRAM
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int RD_WAIT  = 2,
  parameter int WR_PULSE = 2
) (
  input  logic                clk,
  input  logic                rst,
  sram_port_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(max2(RD_WAIT, WR_PULSE)) + 1;
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_PULSE - 1);

  state_e            state_q;
  port_e             port_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;
  logic              ce_n_q, oe_n_q, we_n_q, dq_oe_q;
  logic [BE_W-1:0]   be_n_q;
  logic              inst_ready_q, data_ready_q;
  logic [DATA_W-1:0] inst_rdata_q, data_rdata_q;
  logic              inst_lock_q, data_lock_q;

  logic inst_req, data_req, inst_go, data_go;

  always_comb begin
    inst_req = bus.inst_read;
    data_req = bus.data_read | bus.data_write;
    inst_go  = inst_req & ~inst_lock_q;
    data_go  = data_req & ~data_lock_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      port_q       <= PORT_INST;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      ce_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
      we_n_q       <= 1'b1;
      be_n_q       <= '1;
      dq_oe_q      <= 1'b0;
      inst_ready_q <= 1'b0;
      data_ready_q <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
      inst_lock_q  <= 1'b0;
      data_lock_q  <= 1'b0;
    end else begin
      inst_ready_q <= 1'b0;
      data_ready_q <= 1'b0;
      // A lock set below on completion wins over this clear in the same cycle
      if (!inst_req) inst_lock_q <= 1'b0;
      if (!data_req) data_lock_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (data_go && bus.data_write) begin
            port_q  <= PORT_DATA;
            addr_q  <= bus.data_addr;
            wdata_q <= bus.data_wdata;
            be_q    <= bus.data_be;
            ce_n_q  <= 1'b0;
            dq_oe_q <= 1'b1;
            state_q <= ST_WSETUP;
          end else if (data_go) begin
            port_q  <= PORT_DATA;
            addr_q  <= bus.data_addr;
            ce_n_q  <= 1'b0;
            oe_n_q  <= 1'b0;
            be_n_q  <= '0;
            cnt_q   <= RD_LOAD;
            state_q <= ST_READ;
          end else if (inst_go) begin
            port_q  <= PORT_INST;
            addr_q  <= bus.inst_addr;
            ce_n_q  <= 1'b0;
            oe_n_q  <= 1'b0;
            be_n_q  <= '0;
            cnt_q   <= RD_LOAD;
            state_q <= ST_READ;
          end
        end

        ST_READ: begin
          if (cnt_q == '0) begin
            if (port_q == PORT_DATA) begin
              data_rdata_q <= bus.sram_dq_i;
              data_ready_q <= 1'b1;
              data_lock_q  <= 1'b1;
            end else begin
              inst_rdata_q <= bus.sram_dq_i;
              inst_ready_q <= 1'b1;
              inst_lock_q  <= 1'b1;
            end
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            be_n_q  <= '1;
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        ST_WSETUP: begin
          we_n_q  <= 1'b0;
          be_n_q  <= ~be_q;
          cnt_q   <= WR_LOAD;
          state_q <= ST_WPULSE;
        end

        ST_WPULSE: begin
          if (cnt_q == '0) begin
            we_n_q  <= 1'b1;
            be_n_q  <= '1;
            state_q <= ST_WHOLD;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        ST_WHOLD: begin
          // Only the data port issues writes
          ce_n_q       <= 1'b1;
          dq_oe_q      <= 1'b0;
          data_ready_q <= 1'b1;
          data_lock_q  <= 1'b1;
          state_q      <= ST_DONE;
        end

        ST_DONE: state_q <= ST_IDLE;

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.inst_ready = inst_ready_q;
  assign bus.inst_rdata = inst_rdata_q;
  assign bus.data_ready = data_ready_q;
  assign bus.data_rdata = data_rdata_q;
  assign bus.sram_addr  = addr_q;
  assign bus.sram_dq_o  = wdata_q;
  assign bus.sram_dq_oe = dq_oe_q;
  assign bus.sram_ce_n  = ce_n_q;
  assign bus.sram_oe_n  = oe_n_q;
  assign bus.sram_we_n  = we_n_q;
  assign bus.sram_be_n  = be_n_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - scoreboard bench for sram_port_arbiter with an SRAM model
module tb_sram_port_arbiter;

  localparam int RD_WAIT  = 2;
  localparam int WR_PULSE = 2;
  localparam int K_INST = 0, K_RD = 1, K_WR = 2, K_RW = 3;

  typedef struct {
    bit          is_data;
    logic [31:0] rdata;
  } sb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_preload = 1'b1;

  sram_port_arbiter_if sif();

  sram_port_arbiter #(.RD_WAIT(RD_WAIT), .WR_PULSE(WR_PULSE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  sb_t sb_q[$];
  logic [31:0] ref_mem [int];
  logic [31:0] exp_inst_rdata = '0;
  logic [31:0] exp_data_rdata = '0;
  logic [3:0]  exp_be_n = 4'hF;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // SRAM model: combinational read, byte-masked write while we_n is low
  logic [31:0] sram_mem [0:1023];

  always @(posedge clk) begin
    if (mem_preload) begin
      for (int i = 0; i < 1024; i++) sram_mem[i] <= 32'h0;
      sram_mem[16] <= 32'h2402_0005;
    end else if (!sif.sram_ce_n && !sif.sram_we_n && sif.sram_dq_oe) begin
      for (int b = 0; b < 4; b++)
        if (!sif.sram_be_n[b]) sram_mem[sif.sram_addr[9:0]][8*b +: 8] <= sif.sram_dq_o[8*b +: 8];
    end
  end

  always_comb sif.sram_dq_i = (!sif.sram_ce_n && !sif.sram_oe_n) ? sram_mem[sif.sram_addr[9:0]] : 32'h0;

  function automatic logic [31:0] ref_rd(input logic [17:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 32'h0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_read(input bit is_data, input logic [17:0] a);
    sb_t e;
    e.is_data = is_data;
    e.rdata   = ref_rd(a);
    if (is_data) exp_data_rdata = e.rdata;
    else         exp_inst_rdata = e.rdata;
    sb_q.push_back(e);
  endtask

  task automatic wait_for(input bit is_data, output int n);
    bit got = 1'b0;
    n = 0;
    while (!got && n < 20) begin
      tick();
      n++;
      got = is_data ? sif.data_ready : sif.inst_ready;
    end
    check("ready_seen", 32'(got), 32'd1);
  endtask

  task automatic xact(input int kind, input logic [17:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, input bit drop_early);
    sb_t e;
    int n, lat;
    bit got, is_data, is_wr;
    logic [31:0] tmp;
    is_data = (kind != K_INST);
    is_wr   = (kind == K_WR) || (kind == K_RW);
    if (is_wr) begin
      tmp = ref_rd(addr);
      for (int b = 0; b < 4; b++) if (be[b]) tmp[8*b +: 8] = wdata[8*b +: 8];
      ref_mem[int'(addr)] = tmp;
      exp_be_n  = ~be;
      e.is_data = 1'b1;
      e.rdata   = exp_data_rdata;
      sb_q.push_back(e);
      lat = WR_PULSE + 3;
    end else begin
      push_read(is_data, addr);
      lat = RD_WAIT + 1;
    end
    if (is_data) begin
      sif.data_addr  = addr;
      sif.data_wdata = wdata;
      sif.data_be    = be;
      sif.data_read  = (kind == K_RD) || (kind == K_RW);
      sif.data_write = is_wr;
    end else begin
      sif.inst_addr = addr;
      sif.inst_read = 1'b1;
    end
    got = 1'b0;
    n = 0;
    while (!got && n < 20) begin
      tick();
      n++;
      if (n == 1) begin
        check("addr_latch", 32'(sif.sram_addr), 32'(addr));
        check("ce_n_active", 32'(sif.sram_ce_n), 32'd0);
        if (is_wr) begin
          check("wsetup_ctl", 32'({sif.sram_we_n, sif.sram_oe_n, sif.sram_dq_oe}), 32'b111);
          check("wdata_drive", sif.sram_dq_o, wdata);
        end else begin
          check("read_ctl", 32'({sif.sram_we_n, sif.sram_oe_n, sif.sram_dq_oe, sif.sram_be_n}), 32'b1000000);
        end
        // Inputs changed after acceptance must not reach the SRAM
        sif.inst_addr  = ~addr;
        sif.data_addr  = ~addr;
        sif.data_wdata = ~wdata;
        sif.data_be    = ~be;
        if (drop_early) begin
          if (is_data) begin sif.data_read = 1'b0; sif.data_write = 1'b0; end
          else sif.inst_read = 1'b0;
        end
      end
      got = is_data ? sif.data_ready : sif.inst_ready;
    end
    check("ready_seen", 32'(got), 32'd1);
    check("latency", 32'(n), 32'(lat));
    if (is_data) begin sif.data_read = 1'b0; sif.data_write = 1'b0; end
    else sif.inst_read = 1'b0;
    tick();
  endtask

  // Bus invariants, write-pulse shape and scoreboard consumption
  always @(negedge clk) begin
    sb_t e;
    check("dq_oe_vs_oe_n", 32'(sif.sram_dq_oe && !sif.sram_oe_n), 32'd0);
    check("one_ready", 32'(sif.inst_ready && sif.data_ready), 32'd0);
    if (rst) begin
      we_cnt = 0;
    end else begin
      if (!sif.sram_we_n) begin
        we_cnt++;
        check("be_n_pulse", 32'(sif.sram_be_n), 32'(exp_be_n));
      end else if (we_cnt != 0) begin
        check("we_width", 32'(we_cnt), 32'(WR_PULSE));
        we_cnt = 0;
      end
      if (sif.inst_ready || sif.data_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_empty", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("ready_port", 32'(sif.data_ready), 32'(e.is_data));
          check("rdata", e.is_data ? sif.data_rdata : sif.inst_rdata, e.rdata);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    sif.inst_read  = 1'b0;
    sif.inst_addr  = '0;
    sif.data_read  = 1'b0;
    sif.data_write = 1'b0;
    sif.data_addr  = '0;
    sif.data_wdata = '0;
    sif.data_be    = '0;
    ref_mem[16] = 32'h2402_0005;
    repeat (3) tick();
    mem_preload = 1'b0;
    rst = 1'b0;

    check("rst_ctl", 32'({sif.sram_ce_n, sif.sram_oe_n, sif.sram_we_n, sif.sram_dq_oe, sif.sram_be_n}), 32'b11101111);
    check("rst_ready", 32'({sif.inst_ready, sif.data_ready}), 32'd0);
    check("rst_rdata", sif.inst_rdata | sif.data_rdata, 32'd0);
    check("rst_addr", 32'(sif.sram_addr), 32'd0);

    // Instruction fetch from preloaded word
    xact(K_INST, 18'h00010, 32'h0, 4'h0, 1'b0);
    // Low-half byte write, then readback over prior zero
    xact(K_WR, 18'h00100, 32'hDEAD_BEEF, 4'b0011, 1'b0);
    xact(K_RD, 18'h00100, 32'h0, 4'h0, 1'b0);

    // Simultaneous requests: data first, instruction after DONE and IDLE
    push_read(1'b1, 18'h00100);
    push_read(1'b0, 18'h00010);
    sif.data_addr = 18'h00100;
    sif.inst_addr = 18'h00010;
    sif.data_read = 1'b1;
    sif.inst_read = 1'b1;
    wait_for(1'b1, n);
    check("dual_data_lat", 32'(n), 32'(RD_WAIT + 1));
    sif.data_read = 1'b0;
    wait_for(1'b0, n);
    check("dual_inst_lat", 32'(n), 32'(RD_WAIT + 2));
    sif.inst_read = 1'b0;
    tick();

    // Held request after ready is locked out until it drops for a cycle
    push_read(1'b1, 18'h00100);
    sif.data_addr = 18'h00100;
    sif.data_read = 1'b1;
    wait_for(1'b1, n);
    check("lock_first_lat", 32'(n), 32'(RD_WAIT + 1));
    repeat (6) begin
      tick();
      check("lock_no_ce", 32'(sif.sram_ce_n), 32'd1);
      check("lock_no_ready", 32'(sif.data_ready), 32'd0);
    end
    sif.data_read = 1'b0;
    tick();
    push_read(1'b1, 18'h00010);
    sif.data_addr = 18'h00010;
    sif.data_read = 1'b1;
    wait_for(1'b1, n);
    check("lock_relaunch_lat", 32'(n), 32'(RD_WAIT + 1));
    sif.data_read = 1'b0;
    tick();

    // Request dropped right after acceptance still completes
    xact(K_INST, 18'h00100, 32'h0, 4'h0, 1'b1);
    xact(K_WR, 18'h00104, 32'hA5A5_5A5A, 4'b1010, 1'b1);
    // Read and write together act as a write
    xact(K_RW, 18'h00101, 32'h1234_5678, 4'hF, 1'b0);
    xact(K_INST, 18'h00101, 32'h0, 4'h0, 1'b0);
    xact(K_RD, 18'h00104, 32'h0, 4'h0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      xact($urandom_range(0, 2), 18'h00020 + 18'($urandom_range(0, 3)), $urandom,
           4'($urandom_range(1, 15)), 1'b0);
    end

    // Reset in the middle of the write pulse
    exp_be_n = 4'b0000;
    sif.data_addr  = 18'h00200;
    sif.data_wdata = 32'h0BAD_F00D;
    sif.data_be    = 4'hF;
    sif.data_write = 1'b1;
    n = 0;
    while (sif.sram_we_n && n < 10) begin
      tick();
      n++;
    end
    check("wpulse_reached", 32'(sif.sram_we_n), 32'd0);
    rst = 1'b1;
    tick();
    sif.data_write = 1'b0;
    check("rst_mid_we_n", 32'(sif.sram_we_n), 32'd1);
    check("rst_mid_dq_oe", 32'(sif.sram_dq_oe), 32'd0);
    check("rst_mid_ce_oe", 32'({sif.sram_ce_n, sif.sram_oe_n, sif.sram_be_n}), 32'b111111);
    check("rst_mid_ready", 32'({sif.inst_ready, sif.data_ready}), 32'd0);
    check("rst_mid_rdata", sif.inst_rdata | sif.data_rdata, 32'd0);
    check("rst_mid_addr", 32'(sif.sram_addr), 32'd0);
    rst = 1'b0;
    exp_inst_rdata = '0;
    exp_data_rdata = '0;
    repeat (5) begin
      tick();
      check("rst_no_ready", 32'({sif.inst_ready, sif.data_ready}), 32'd0);
    end
    xact(K_INST, 18'h00010, 32'h0, 4'h0, 1'b0);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 Parameter RD_WAIT, default 2: cycles the address is held with oe_n low before read data is sampled; minimum 1.
REQ-002 Parameter WR_PULSE, default 2: cycles sram_we_n is held low per write; minimum 1.
REQ-003 clk  in  1  clock; all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 inst_read  in  1  instruction read request, level, held until inst_ready.
REQ-006 inst_addr  in  18  instruction word address.
REQ-007 inst_ready  out  1  one-cycle completion pulse, instruction port.
REQ-008 inst_rdata  out  32  instruction read data, registered.
REQ-009 data_read / data_write  in  1 each  data port requests, level, held until data_ready.
REQ-010 data_addr  in  18  data word address; data_wdata  in  32  write data; data_be  in  4  byte enables, bit0 = bits 7:0.
REQ-011 data_ready  out  1  one-cycle completion pulse, data port; data_rdata  out  32  registered read data.
REQ-012 sram_addr  out  18; sram_dq_o  out  32; sram_dq_oe  out  1 (tristate enable); sram_dq_i  in  32.
REQ-013 sram_ce_n, sram_oe_n, sram_we_n  out  1 each; sram_be_n  out  4; all active-low.

Function
REQ-014 Single shared asynchronous SRAM; at most one transaction in flight.
REQ-015 FSM states: IDLE, READ, WSETUP, WPULSE, WHOLD, DONE.
REQ-016 New requests accepted only in IDLE; priority data_write > data_read > inst_read; simultaneous data_read and data_write treated as write.
REQ-017 Per-port lockout: after a port's ready pulse, its requests are ignored until sampled low for at least one cycle.
REQ-018 Accept edge latches address, wdata, be and requesting port into internal registers; later input changes are ignored.
REQ-019 Read: IDLE -> READ for RD_WAIT cycles (ce_n=0, oe_n=0, be_n=0000); sram_dq_i captured on last READ edge into the port's rdata register -> DONE.
REQ-020 Write: IDLE -> WSETUP 1 cycle (ce_n=0, we_n=1, dq_oe=1) -> WPULSE WR_PULSE cycles (we_n=0, be_n=~be) -> WHOLD 1 cycle (we_n=1, data still driven) -> DONE.
REQ-021 DONE lasts exactly 1 cycle: ready of the owning port high, then IDLE.
REQ-022 Latency: read ready high in the cycle after the RD_WAIT-th edge after acceptance; write ready after the (WR_PULSE+2)-th edge.
REQ-023 rdata registers hold value until the next read completing on that port; writes never alter them.
REQ-024 Request dropped mid-transaction: transaction still completes and ready still pulses.
REQ-025 sram_dq_oe high only in WSETUP, WPULSE, WHOLD; never high while oe_n low.
REQ-026 All SRAM control outputs and ready outputs registered, glitch-free; wait counter width clog2(max(RD_WAIT,WR_PULSE))+1.
REQ-027 IDLE outputs: ce_n=1, oe_n=1, we_n=1, be_n=1111, dq_oe=0.

Reset
REQ-028 rst (any state, including mid-WPULSE) -> IDLE on the next edge; ready outputs 0, rdata 0, sram_addr 0, controls per REQ-027, lockouts cleared, counter 0.

Structure
REQ-029 Shared package holds state enum, ADDR_W=18, DATA_W=32, BE_W=4.
REQ-030 Single module, no sub-modules; tristate buffer instantiated at board top level.

Verification
REQ-031 inst_read=1, addr 0x00010, SRAM model returns 0x2402_0005 -> inst_ready pulse 2 cycles after accept, inst_rdata=0x2402_0005.
REQ-032 data_write, addr 0x00100, wdata 0xDEAD_BEEF, be 0011 -> we_n low exactly 2 cycles, be_n=1100, data_ready after 4th edge; readback 0x0000_BEEF over prior zero.
REQ-033 inst_read and data_read asserted same cycle -> data served first; inst_ready follows data_ready by read latency + 1 IDLE cycle.
REQ-034 Requester holds data_read high after data_ready -> no second transaction until request low one cycle.
REQ-035 rst asserted during WPULSE -> next cycle we_n=1, dq_oe=0, state IDLE, no ready pulse.
REQ-036 Every cycle: assert !(sram_dq_oe && !sram_oe_n) and at most one ready high.
